// File: rtl/motoro3_step_sequencer.sv
// Commutation step scheduler: IDLE -> ALIGN -> RUN -> STOP, 12-step index, in-step counter and strobes.
// Optional start-up length ramp is compiled in with `define M3_SEQ_RAMP_EN.
module motoro3_step_sequencer (
    input  logic        clk,
    input  logic        nRst,
    input  logic        m3r_enable,
    input  logic        m3r_dirRev,
    input  logic [24:0] m3r_stepLen,
    input  logic [3:0]  m3r_alignSteps,
    input  logic [24:0] m3r_stepLenStart,
    input  logic [15:0] m3r_rampDec,
    output logic [3:0]  sgStep,
    output logic [24:0] m3cnt,
    output logic        m3cntFirst2,
    output logic        m3cntFirst1,
    output logic        m3cntLast2,
    output logic        m3cntLast1,
    output logic        pwmActive1,
    output logic        m3revPulse
);

    localparam logic [24:0] LEN_MIN   = 25'd4;
    localparam logic [3:0]  STEP_IDLE = 4'd15;
    localparam logic [3:0]  STEP_MAX  = 4'd11;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ALIGN = 2'd1,
        S_RUN   = 2'd2,
        S_STOP  = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  step_q,  step_d;
    logic [24:0] cnt_q,   cnt_d;
    logic [24:0] len_q,   len_d;
    logic [3:0]  align_q, align_d;
    logic        pwm_q,   pwm_d;
    logic        rev_q,   rev_d;
    logic        f2_q, f1_q, l2_q, l1_q;
    logic        f2_d, f1_d, l2_d, l1_d;

    function automatic logic [24:0] clamp_len(input logic [24:0] v);
        return (v < LEN_MIN) ? LEN_MIN : v;
    endfunction

    logic [24:0] target_len;
    logic [24:0] start_len;
    logic [24:0] run_len;
    logic [24:0] align_len;

    assign target_len = clamp_len(m3r_stepLen);

`ifdef M3_SEQ_RAMP_EN
    logic [24:0] dec_ext;
    logic [24:0] ramp_sub;

    assign dec_ext   = {9'd0, m3r_rampDec};
    assign ramp_sub  = (len_q > dec_ext) ? (len_q - dec_ext) : 25'd0;
    assign start_len = clamp_len(m3r_stepLenStart);
    // Ramp down towards the target, never undershooting it.
    assign run_len   = (len_q > target_len) ?
                       ((ramp_sub > target_len) ? ramp_sub : target_len) : target_len;
    assign align_len = len_q;
`else
    logic unused_ramp;

    assign unused_ramp = ^{m3r_stepLenStart, m3r_rampDec};
    assign start_len   = target_len;
    assign run_len     = target_len;
    assign align_len   = target_len;
`endif

    logic        boundary;
    logic [3:0]  adv_step;
    logic        adv_wrap;

    assign boundary = (cnt_q == len_q - 25'd1);

    always_comb begin
        adv_step = step_q + 4'd1;
        adv_wrap = 1'b0;
        if (m3r_dirRev) begin
            adv_step = step_q - 4'd1;
            if (step_q == 4'd0) begin
                adv_step = STEP_MAX;
                adv_wrap = 1'b1;
            end
        end else if (step_q == STEP_MAX) begin
            adv_step = 4'd0;
            adv_wrap = 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        cnt_d   = cnt_q;
        len_d   = len_q;
        align_d = align_q;
        pwm_d   = pwm_q;
        rev_d   = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (m3r_enable) begin
                    state_d = S_ALIGN;
                    step_d  = 4'd0;
                    cnt_d   = 25'd0;
                    pwm_d   = 1'b1;
                    len_d   = start_len;
                    align_d = (m3r_alignSteps == 4'd0) ? 4'd1 : m3r_alignSteps;
                end
            end

            S_ALIGN, S_RUN: begin
                cnt_d = cnt_q + 25'd1;
                if (boundary) begin
                    cnt_d = 25'd0;
                    // Disable seen on the last cycle: the step is already complete.
                    if (!m3r_enable) begin
                        state_d = S_IDLE;
                        step_d  = STEP_IDLE;
                        pwm_d   = 1'b0;
                    end else if (state_q == S_RUN || align_q <= 4'd1) begin
                        state_d = S_RUN;
                        step_d  = adv_step;
                        rev_d   = adv_wrap;
                        len_d   = run_len;
                        align_d = 4'd0;
                    end else begin
                        align_d = align_q - 4'd1;
                        len_d   = align_len;
                    end
                end else if (!m3r_enable) begin
                    state_d = S_STOP;
                end
            end

            S_STOP: begin
                cnt_d = cnt_q + 25'd1;
                if (boundary) begin
                    state_d = S_IDLE;
                    step_d  = STEP_IDLE;
                    cnt_d   = 25'd0;
                    pwm_d   = 1'b0;
                end
            end

            default: begin
                state_d = S_IDLE;
                step_d  = STEP_IDLE;
                cnt_d   = 25'd0;
                pwm_d   = 1'b0;
            end
        endcase

        // Strobes are decoded from next-state so they line up with the registered count.
        f2_d = (state_d != S_IDLE) && (cnt_d == 25'd0);
        f1_d = (state_d != S_IDLE) && (cnt_d == 25'd1);
        l2_d = (state_d != S_IDLE) && (cnt_d == len_d - 25'd2);
        l1_d = (state_d != S_IDLE) && (cnt_d == len_d - 25'd1);
    end

    always_ff @(negedge clk or negedge nRst) begin
        if (!nRst) begin
            state_q <= S_IDLE;
            step_q  <= STEP_IDLE;
            cnt_q   <= 25'd0;
            len_q   <= LEN_MIN;
            align_q <= 4'd0;
            pwm_q   <= 1'b0;
            rev_q   <= 1'b0;
            f2_q    <= 1'b0;
            f1_q    <= 1'b0;
            l2_q    <= 1'b0;
            l1_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
            align_q <= align_d;
            pwm_q   <= pwm_d;
            rev_q   <= rev_d;
            f2_q    <= f2_d;
            f1_q    <= f1_d;
            l2_q    <= l2_d;
            l1_q    <= l1_d;
        end
    end

    assign sgStep      = step_q;
    assign m3cnt       = cnt_q;
    assign m3cntFirst2 = f2_q;
    assign m3cntFirst1 = f1_q;
    assign m3cntLast2  = l2_q;
    assign m3cntLast1  = l1_q;
    assign pwmActive1  = pwm_q;
    assign m3revPulse  = rev_q;

endmodule

// File: doc/motoro3_step_sequencer.md
# motoro3_step_sequencer

Commutation step scheduler for the 3-phase motor datapath. It generates the step index `sgStep`, the in-step counter `m3cnt` and the first/last-cycle strobes. It also drives `pwmActive1`. Together these sequence the PWM generator and its per-step position accumulators. It runs a start → align → run → stop state machine and changes the step length only at step boundaries.

## Interface
- No parameters.
- `clk`  in  1  system clock, 10 MHz; all state updates on the falling edge.
- `nRst`  in  1  asynchronous active-low reset.
- `m3r_enable`  in  1  run request, level-sensitive.
- `m3r_dirRev`  in  1  step order: 0 = ascending, 1 = descending. Sampled at step boundaries.
- `m3r_stepLen`  in  25  target step length in clocks.
- `m3r_alignSteps`  in  4  number of whole step periods spent in ALIGN.
- `m3r_stepLenStart`  in  25  initial step length (ramp only).
- `m3r_rampDec`  in  16  per-step length decrement (ramp only).
- `sgStep`  out  4  current step, 0..11; 15 = inactive.
- `m3cnt`  out  25  clocks elapsed in the current step.
- `m3cntFirst2`  out  1  high while `m3cnt` = 0.
- `m3cntFirst1`  out  1  high while `m3cnt` = 1.
- `m3cntLast2`  out  1  high while `m3cnt` = len−2.
- `m3cntLast1`  out  1  high while `m3cnt` = len−1.
- `pwmActive1`  out  1  high in ALIGN, RUN and STOP.
- `m3revPulse`  out  1  one-cycle strobe on an 11→0 (or 0→11 when reversed) step transition.

## Operation
- States: IDLE, ALIGN, RUN, STOP.
- Reset values: state IDLE, `sgStep` = 15, `m3cnt` = 0, all strobes 0, `pwmActive1` = 0, `m3revPulse` = 0, `len` = 4.
- `len` is the internal latched step length. It is always clamped to a minimum of 4, so the four strobes fall on distinct cycles.
- IDLE → ALIGN when `m3r_enable` = 1:
  - `sgStep` ← 0, `m3cnt` ← 0, `pwmActive1` ← 1.
  - `len` ← clamp(`m3r_stepLen`), or clamp(`m3r_stepLenStart`) with the ramp feature.
  - The align-step counter is loaded with `m3r_alignSteps`.
- In ALIGN, RUN and STOP, `m3cnt` increments each cycle. At `m3cnt` = len−1 (the boundary cycle) it wraps to 0.
- ALIGN:
  - `sgStep` stays at 0 and each boundary decrements the align counter.
  - When the counter reaches 0 at a boundary, go to RUN and take the first step advance.
  - `m3r_alignSteps` = 0 behaves as 1.
- RUN, at each boundary:
  - `sgStep` ← `sgStep`+1, with 11 wrapping to 0; if `m3r_dirRev` = 1, `sgStep` ← `sgStep`−1, with 0 wrapping to 11.
  - `len` is re-latched.
  - `m3revPulse` fires in the cycle after the wrap boundary, coincident with the new `sgStep`.
- `m3r_enable` = 0 seen in ALIGN or RUN → STOP. The current step completes through its `m3cntLast1` cycle.
- STOP → IDLE at the boundary: `sgStep` ← 15, `m3cnt` ← 0, `pwmActive1` ← 0. A boundary in STOP does not advance `sgStep`.
- `m3r_enable` reasserted during STOP is ignored until IDLE is reached. IDLE then restarts on the following cycle.
- Strobes are 0 in IDLE. Strobes are registered and coincide with the matching `m3cnt` value.
- Register changes to `m3r_stepLen` or `m3r_dirRev` mid-step have no effect until the next boundary.

## Timing
- Enable-to-active latency: `m3r_enable` sampled high at falling edge N → `pwmActive1` = 1, `sgStep` = 0 and `m3cntFirst2` = 1 after edge N.
- Step period is exactly `len` clocks. `m3cntLast1` and `m3cntFirst2` occur on consecutive cycles across a boundary.
- Stop latency: at most one step period plus one clock.
- Asynchronous reset mid-step returns all outputs to reset values immediately, with no partial step.

## Configuration
- Macro `M3_SEQ_RAMP_EN` defined (ramp enabled):
  - IDLE→ALIGN loads `len` from `m3r_stepLenStart`, and ALIGN holds that length.
  - At each RUN boundary, including the ALIGN→RUN boundary: if `len` > target, then `len` ← max(`len` − `m3r_rampDec`, target); otherwise `len` ← target.
  - target = clamp(`m3r_stepLen`); the subtraction saturates at 0 before the clamp.
- Macro undefined: `len` is always clamp(`m3r_stepLen`), and `m3r_stepLenStart` / `m3r_rampDec` are ignored. The ports remain present.

## Test plan
- Reset asserted mid-RUN → `sgStep` = 15, `m3cnt` = 0, `pwmActive1` = 0, all strobes 0, with no clock edge required.
- `m3r_stepLen` = 10, `m3r_alignSteps` = 2, enable → 20 clocks at step 0, then steps 1, 2, … each 10 clocks.
  - `m3cntFirst2` at `m3cnt` 0, `m3cntFirst1` at 1, `m3cntLast2` at 8, `m3cntLast1` at 9.
  - `m3revPulse` when the step goes 11→0.
- `m3r_stepLen` = 2 → step period is 4; strobes fall at `m3cnt` 0, 1, 2, 3.
- Enable dropped at `m3cnt` = 3 of step 5 with length 10 → step 5 completes to `m3cnt` 9, then `sgStep` = 15 and `pwmActive1` = 0. Enable re-raised during STOP → restart at step 0 one cycle after IDLE.
- `m3r_dirRev` = 1 → step sequence 0 (align), 11, 10, 9, …; `m3revPulse` on the 0→11 transition.
- With `M3_SEQ_RAMP_EN`: start = 100, dec = 10, target = 60, `m3r_alignSteps` = 1 → step lengths 100, 90, 80, 70, 60, 60.
